stoplight_monitor: RTL and testbench

Safety monitor and lamp driver that sits directly downstream of the Stoplight controller. It samples the controller's one-hot `light_pros`/`light_wash` outputs every clock tick and checks encoding, cross-road conflicts, illegal colour sequences and yellow duration. While the signals are legal it forwards them to the lamp outputs. On the first violation it latches a fault code and forces both roads into flashing red until reset.

---
 rtl/stoplight_monitor.sv | 190 +++++++++++++++++++
 tb/tb_stoplight_monitor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stoplight_monitor.sv
// Safety monitor and lamp driver for the Stoplight controller: forwards legal colours, latches the first fault and flashes red.
// Optional all-red watchdog (fault code 5) compiled in with `define STOPLIGHT_MON_WDOG_EN.
module stoplight_monitor #(
    parameter int unsigned MIN_YLW    = 1,
    parameter int unsigned FLASH_HALF = 1,
    parameter int unsigned MAX_ALLRED = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_pros,
    input  logic [2:0] light_wash,
    output logic [2:0] lamp_pros,
    output logic [2:0] lamp_wash,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] DARK = 3'b000;
    localparam logic [7:0] MIN_YLW_C  = 8'(MIN_YLW);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_PASS  = 2'd1,
        S_FLASH = 2'd2
    } state_e;

    function automatic logic is_color(input logic [2:0] c);
        return (c == GRN) || (c == YLW) || (c == RED);
    endfunction

    function automatic logic bad_step(input logic [2:0] p, input logic [2:0] c);
        return ((p == GRN) && (c == RED)) || ((p == RED) && (c == YLW)) || ((p == YLW) && (c == GRN));
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Yellow length seen so far, including the current sample.
    function automatic logic [7:0] ylw_next(input logic [2:0] p, input logic [2:0] c, input logic [7:0] cnt);
        if (c != YLW) begin
            return 8'd0;
        end else if (p != YLW) begin
            return 8'd1;
        end else begin
            return sat_inc(cnt);
        end
    endfunction

    state_e     state_q, state_d;
    logic [2:0] lamp_pros_q, lamp_pros_d, lamp_wash_q, lamp_wash_d;
    logic [2:0] prev_pros_q, prev_pros_d, prev_wash_q, prev_wash_d;
    logic [7:0] ylw_pros_q, ylw_pros_d, ylw_wash_q, ylw_wash_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [2:0] chk_code_s;
    logic       pass_s, short_s;

`ifdef STOPLIGHT_MON_WDOG_EN
    localparam logic [7:0] ALLRED_LIM = 8'(MAX_ALLRED);
    logic [7:0] allred_q, allred_d, allred_nxt_s;
    assign allred_nxt_s = ((light_pros == RED) && (light_wash == RED)) ? sat_inc(allred_q) : 8'd0;
`else
    // MAX_ALLRED only matters to the watchdog build; reference it so it stays visible.
    if (MAX_ALLRED == 0) begin : g_allred_unused
    end
`endif

    assign pass_s  = (state_q == S_PASS);
    assign short_s = ((prev_pros_q == YLW) && (light_pros == RED) && (ylw_pros_q < MIN_YLW_C)) ||
                     ((prev_wash_q == YLW) && (light_wash == RED) && (ylw_wash_q < MIN_YLW_C));

    // Prioritised check result; lowest code wins, INIT skips history-based checks.
    always_comb begin
        chk_code_s = 3'd0;
        if (!(is_color(light_pros) && is_color(light_wash))) begin
            chk_code_s = 3'd1;
        end else if ((light_pros != RED) && (light_wash != RED)) begin
            chk_code_s = 3'd2;
        end else if (pass_s && (bad_step(prev_pros_q, light_pros) || bad_step(prev_wash_q, light_wash))) begin
            chk_code_s = 3'd3;
        end else if (pass_s && short_s) begin
            chk_code_s = 3'd4;
`ifdef STOPLIGHT_MON_WDOG_EN
        end else if (pass_s && (allred_nxt_s > ALLRED_LIM)) begin
            chk_code_s = 3'd5;
`endif
        end else begin
            chk_code_s = 3'd0;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        lamp_pros_d = lamp_pros_q;
        lamp_wash_d = lamp_wash_q;
        prev_pros_d = prev_pros_q;
        prev_wash_d = prev_wash_q;
        ylw_pros_d  = ylw_pros_q;
        ylw_wash_d  = ylw_wash_q;
        flash_cnt_d = flash_cnt_q;
        fault_d     = fault_q;
        code_d      = code_q;
`ifdef STOPLIGHT_MON_WDOG_EN
        allred_d    = allred_q;
`endif
        case (state_q)
            S_INIT, S_PASS: begin
                if (chk_code_s != 3'd0) begin
                    fault_d     = 1'b1;
                    code_d      = chk_code_s;
                    state_d     = S_FLASH;
                    lamp_pros_d = RED;
                    lamp_wash_d = RED;
                    flash_cnt_d = 8'd0;
                end else begin
                    lamp_pros_d = light_pros;
                    lamp_wash_d = light_wash;
                    prev_pros_d = light_pros;
                    prev_wash_d = light_wash;
                    ylw_pros_d  = ylw_next(prev_pros_q, light_pros, ylw_pros_q);
                    ylw_wash_d  = ylw_next(prev_wash_q, light_wash, ylw_wash_q);
`ifdef STOPLIGHT_MON_WDOG_EN
                    allred_d    = allred_nxt_s;
`endif
                    state_d     = S_PASS;
                end
            end
            S_FLASH: begin
                if (flash_cnt_q >= FLASH_LAST) begin
                    flash_cnt_d = 8'd0;
                    lamp_pros_d = (lamp_pros_q == RED) ? DARK : RED;
                    lamp_wash_d = (lamp_pros_q == RED) ? DARK : RED;
                end else begin
                    flash_cnt_d = flash_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = S_INIT;
                lamp_pros_d = RED;
                lamp_wash_d = RED;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            lamp_pros_q <= RED;
            lamp_wash_q <= RED;
            prev_pros_q <= RED;
            prev_wash_q <= RED;
            ylw_pros_q  <= 8'd0;
            ylw_wash_q  <= 8'd0;
            flash_cnt_q <= 8'd0;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
`ifdef STOPLIGHT_MON_WDOG_EN
            allred_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            lamp_pros_q <= lamp_pros_d;
            lamp_wash_q <= lamp_wash_d;
            prev_pros_q <= prev_pros_d;
            prev_wash_q <= prev_wash_d;
            ylw_pros_q  <= ylw_pros_d;
            ylw_wash_q  <= ylw_wash_d;
            flash_cnt_q <= flash_cnt_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
`ifdef STOPLIGHT_MON_WDOG_EN
            allred_q    <= allred_d;
`endif
        end
    end

    assign lamp_pros  = lamp_pros_q;
    assign lamp_wash  = lamp_wash_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_stoplight_monitor.sv
// Directed self-checking bench for stoplight_monitor; a second instance uses MIN_YLW=2 for the short-yellow case.
module tb_stoplight_monitor;

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] DRK = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] light_pros = RED;
    logic [2:0] light_wash = GRN;
    logic [2:0] lamp_pros, lamp_wash, fault_code;
    logic       fault;
    logic [2:0] y2_lamp_pros, y2_lamp_wash, y2_fault_code;
    logic       y2_fault;

    int n_checks = 0;
    int n_errors = 0;

    stoplight_monitor dut (
        .clk(clk), .rst(rst), .light_pros(light_pros), .light_wash(light_wash),
        .lamp_pros(lamp_pros), .lamp_wash(lamp_wash), .fault(fault), .fault_code(fault_code)
    );

    stoplight_monitor #(.MIN_YLW(2)) dut_y2 (
        .clk(clk), .rst(rst), .light_pros(light_pros), .light_wash(light_wash),
        .lamp_pros(y2_lamp_pros), .lamp_wash(y2_lamp_wash), .fault(y2_fault), .fault_code(y2_fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_main(input string tag, input logic [2:0] w, input logic [2:0] p,
                               input logic f, input logic [2:0] c);
        check({tag, "_wash"}, lamp_wash, w);
        check({tag, "_pros"}, lamp_pros, p);
        check({tag, "_fault"}, {2'b00, fault}, {2'b00, f});
        check({tag, "_code"}, fault_code, c);
    endtask

    // Apply inputs after the edge, then sample 1 time unit after the next edge.
    task automatic tick(input logic [2:0] w, input logic [2:0] p);
        light_wash = w;
        light_pros = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(GRN, RED);
        expect_main("reset", RED, RED, 1'b0, 3'd0);
        rst = 1'b0;
    endtask

    logic [2:0] cyc_w [5];
    logic [2:0] cyc_p [5];

    initial begin
        cyc_w[0] = GRN; cyc_p[0] = RED;
        cyc_w[1] = GRN; cyc_p[1] = RED;
        cyc_w[2] = YLW; cyc_p[2] = RED;
        cyc_w[3] = RED; cyc_p[3] = GRN;
        cyc_w[4] = RED; cyc_p[4] = YLW;

        // Reset, then first legal sample through INIT
        do_reset();
        tick(GRN, RED);
        expect_main("init_pass", GRN, RED, 1'b0, 3'd0);

        // Legal cycle for 20 ticks: lamps echo inputs one cycle later
        for (int i = 0; i < 20; i++) begin
            tick(cyc_w[i % 5], cyc_p[i % 5]);
            expect_main($sformatf("cycle%0d", i), cyc_w[i % 5], cyc_p[i % 5], 1'b0, 3'd0);
        end

        // Conflict, flash pattern, inputs ignored
        do_reset();
        tick(GRN, RED);
        tick(GRN, GRN);
        expect_main("conflict_k", RED, RED, 1'b1, 3'd2);
        tick(GRN, RED);
        expect_main("conflict_k1", DRK, DRK, 1'b1, 3'd2);
        tick(GRN, RED);
        expect_main("conflict_k2", RED, RED, 1'b1, 3'd2);
        tick(GRN, RED);
        expect_main("conflict_k3", DRK, DRK, 1'b1, 3'd2);

        // Reset mid-flash with lamps dark
        rst = 1'b1;
        tick(GRN, RED);
        expect_main("midflash_rst", RED, RED, 1'b0, 3'd0);
        rst = 1'b0;
        tick(GRN, RED);
        expect_main("resume0", GRN, RED, 1'b0, 3'd0);
        tick(YLW, RED);
        expect_main("resume1", YLW, RED, 1'b0, 3'd0);

        // Illegal transition GRN->RED on wash
        do_reset();
        tick(GRN, RED);
        tick(RED, GRN);
        expect_main("trans", RED, RED, 1'b1, 3'd3);

        // Bad encoding beats conflict
        do_reset();
        tick(GRN, RED);
        tick(GRN, 3'b110);
        expect_main("encode", RED, RED, 1'b1, 3'd1);

        // Single-cycle yellow: fine for MIN_YLW=1, short for MIN_YLW=2
        do_reset();
        tick(GRN, RED);
        tick(YLW, RED);
        check("y2_ylw_fault", {2'b00, y2_fault}, 3'd0);
        tick(RED, GRN);
        expect_main("short_y1", RED, GRN, 1'b0, 3'd0);
        check("short_y2_code", y2_fault_code, 3'd4);
        check("short_y2_fault", {2'b00, y2_fault}, 3'd1);
        check("short_y2_wash", y2_lamp_wash, RED);
        check("short_y2_pros", y2_lamp_pros, RED);

        // All-red held for three cycles
        do_reset();
        tick(GRN, RED);
        tick(YLW, RED);
        tick(RED, RED);
        expect_main("allred1", RED, RED, 1'b0, 3'd0);
        tick(RED, RED);
        expect_main("allred2", RED, RED, 1'b0, 3'd0);
        tick(RED, RED);
`ifdef STOPLIGHT_MON_WDOG_EN
        expect_main("allred3", RED, RED, 1'b1, 3'd5);
`else
        expect_main("allred3", RED, RED, 1'b0, 3'd0);
`endif
        tick(RED, RED);
`ifdef STOPLIGHT_MON_WDOG_EN
        expect_main("allred4", DRK, DRK, 1'b1, 3'd5);
`else
        expect_main("allred4", RED, RED, 1'b0, 3'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
